irrigation_zone_scheduler: RTL
==============================

Name: irrigation_zone_scheduler

Overview:
- Parametrised multi-zone successor to the single-zone tank/irrigation controller.
- Debounces tank level sensors (H/M/L) and per-zone soil/air sensors.
- Drives the tank inlet valve with hysteresis and raises alarm/error flags.
- Time-multiplexes one shared pump across ZONES zones with a round-robin FSM, enforcing minimum/maximum watering time and an inter-zone gap. Choice between drip and sprinkler follows the existing per-zone rule.

Parameters:
- ZONES, 4: number of irrigation zones (1..8).
- DEBOUNCE, 3: consecutive identical synchronised samples needed to accept a sensor change (≥1).
- MIN_ON, 4: minimum cycles a zone valve stays open unless aborted by alarm.
- MAX_ON, 16: maximum cycles per watering turn (MAX_ON ≥ MIN_ON).
- GAP, 2: idle cycles after a turn before the next zone is scanned.
- CNT_W, 8: width of the on-time/gap counter (must hold MAX_ON).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- H  in  1  tank high-level sensor.
- M  in  1  tank mid-level sensor.
- L  in  1  tank low-level sensor.
- T  in  1  high-temperature flag.
- Us  in  ZONES  per-zone soil-saturated flag (1 = no water needed).
- Ua  in  ZONES  per-zone air-humidity flag.
- Ve  out  1  tank inlet valve.
- Al  out  1  alarm (tank empty or sensor fault).
- E  out  1  sensor inconsistency error.
- Bs  out  ZONES  sprinkler valve per zone, one-hot or zero.
- Vs  out  ZONES  drip valve per zone, one-hot or zero.
- busy  out  1  FSM in WATER state.
- active_zone  out  3  index of the zone being watered (0 when idle).

Behaviour:
- Clock and reset are fixed: one clock, reset is asynchronous and active-high.
- Input conditioning:
  - All inputs pass through a 2-FF synchroniser, then a debouncer.
  - Debounced value updates when the synchronised value has differed from it for DEBOUNCE consecutive cycles.
  - Pin-to-debounced latency is 2+DEBOUNCE cycles.
  - Debounced registers reset to 0.
- Tank logic (registered, one cycle after debounced values):
  - E = (M & ~L) | (H & ~M).
  - Al = ~L | E.
  - Ve set when ~M & ~E; cleared when H or E; otherwise holds (hysteresis between M and H).
- Reset values: Ve=0, Al=1, E=0, Bs=0, Vs=0, busy=0, active_zone=0, round-robin pointer=0, FSM=IDLE.
- Zone demand: need[z] = ~Us[z].
- Mode, latched at WATER entry:
  - drip if Ua[z] & (T | ~M).
  - otherwise sprinkler.
- FSM:
  - IDLE: if Al → stay. Else search need[] starting at the pointer, wrapping modulo ZONES. On first hit z: latch z and mode, clear counter, go WATER. No hit → stay.
  - WATER: exactly one of Bs[z]/Vs[z] high; counter increments each cycle.
    - Al → close valve, go IDLE immediately.
    - Else if (Us[z] & counter ≥ MIN_ON) or counter == MAX_ON → go GAP.
  - GAP: valves closed. Pointer = z+1 (wrap to 0 at ZONES). After GAP cycles → IDLE.
- Valve outputs are registered: asserted the cycle after WATER entry, deasserted the cycle after WATER exit.
- Simultaneous events:
  - Al has priority over every other transition.
  - Us[z] changes during WATER do not change the latched mode.
- Never more than one bit set across Bs|Vs.
- Reset asserted mid-operation closes all valves asynchronously.

Optional Feature:
- Macro STICKY_ERROR_EN.
- Defined: once E is set it stays set (and forces Al=1, Ve=0, FSM held in IDLE) until reset.
- Undefined: E and Al track the debounced sensors each cycle and clear when the sensors become consistent.

Test Plan:
- Reset, then hold H=0,M=0,L=0 → Al=1, Ve=1 from 1 cycle after reset; no zone valve ever opens.
- L=1,M=1,H=0, Us=4'b1110, Ua=0, T=0 → after debounce Vs=0, Bs[0]=1.
  - Bs[0] stays high ≥4 cycles.
  - Raising Us[0] at cycle 2 of WATER closes it after cycle 4.
- L=M=H=1, Us=4'b0000, Ua=4'b1111, T=1 → Vs[0..3] open in order.
  - Each open exactly 16 cycles with 2-cycle gaps; pointer wraps 3→0.
- Tank inconsistent H=1,M=0,L=1 during WATER → E=1, Al=1 within 2+3+1 cycles; valve closes next cycle; Ve=0.
  - Restore sensors: with STICKY_ERROR_EN, E stays 1; without it, E clears and scheduling resumes.
- Input glitch on L lasting 2 cycles (<DEBOUNCE) → Al, Ve unchanged.

Source files
------------

// File: rtl/irrigation_zone_scheduler.sv
// rtl/irrigation_zone_scheduler.sv - tank valve control plus round-robin shared-pump zone scheduler
// Optional STICKY_ERROR_EN: E latches until reset, forcing Al=1, Ve=0 and holding the scheduler idle.
module irrigation_zone_scheduler #(
  parameter int ZONES    = 4,
  parameter int DEBOUNCE = 3,
  parameter int MIN_ON   = 4,
  parameter int MAX_ON   = 16,
  parameter int GAP      = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             H,
  input  logic             M,
  input  logic             L,
  input  logic             T,
  input  logic [ZONES-1:0] Us,
  input  logic [ZONES-1:0] Ua,
  output logic             Ve,
  output logic             Al,
  output logic             E,
  output logic [ZONES-1:0] Bs,
  output logic [ZONES-1:0] Vs,
  output logic             busy,
  output logic [2:0]       active_zone
);

  localparam int NIN  = 4 + 2 * ZONES;
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WATER = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [NIN-1:0]  raw, sync_a, sync_b, deb;
  logic [DB_W-1:0] db_cnt [NIN];

  assign raw = {Ua, Us, T, L, M, H};

  // A bit flips only after the synchronised value has disagreed for DEBOUNCE straight cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < NIN; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          deb[i]    <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic             d_h, d_m, d_l, d_t;
  logic [ZONES-1:0] d_us, d_ua;

  assign d_h  = deb[0];
  assign d_m  = deb[1];
  assign d_l  = deb[2];
  assign d_t  = deb[3];
  assign d_us = deb[4 +: ZONES];
  assign d_ua = deb[4 + ZONES +: ZONES];

  logic e_now, e_next;
  assign e_now = (d_m & ~d_l) | (d_h & ~d_m);
`ifdef STICKY_ERROR_EN
  assign e_next = E | e_now;
`else
  assign e_next = e_now;
`endif

  // Inlet valve refills from below M and stops at H, holding in between.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      E  <= 1'b0;
      Al <= 1'b1;
      Ve <= 1'b0;
    end else begin
      E  <= e_next;
      Al <= ~d_l | e_next;
      if (d_h | e_next)
        Ve <= 1'b0;
      else if (~d_m)
        Ve <= 1'b1;
    end
  end

  logic [1:0]       state;
  logic [2:0]       ptr, zone, hit_zone, next_ptr;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             hit, hit_drip, us_cur;
  logic [ZONES-1:0] need_rot, hit_onehot, zone_onehot;

  assign need_rot = ZONES'({~d_us, ~d_us} >> ptr);

  always_comb begin
    int zsum;
    hit  = 1'b0;
    zsum = 0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (need_rot[i]) begin
        hit  = 1'b1;
        zsum = int'(ptr) + i;
      end
    end
    if (zsum >= ZONES) zsum = zsum - ZONES;
    hit_zone = 3'(zsum);
  end

  assign hit_onehot  = ZONES'(1) << hit_zone;
  assign zone_onehot = ZONES'(1) << zone;
  assign hit_drip    = (|(d_ua & hit_onehot)) & (d_t | ~d_m);
  assign us_cur      = |(d_us & zone_onehot);
  assign cnt_inc     = cnt + CNT_W'(1);
  assign next_ptr    = (zone == 3'(ZONES - 1)) ? 3'd0 : zone + 3'd1;
  assign busy        = (state == S_WATER);

  // cnt_inc is the number of WATER cycles completed including the current one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      zone        <= '0;
      cnt         <= '0;
      Bs          <= '0;
      Vs          <= '0;
      active_zone <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!Al && hit) begin
            state       <= S_WATER;
            zone        <= hit_zone;
            cnt         <= '0;
            Bs          <= hit_drip ? '0 : hit_onehot;
            Vs          <= hit_drip ? hit_onehot : '0;
            active_zone <= hit_zone;
          end
        end
        S_WATER: begin
          cnt <= cnt_inc;
          if (Al) begin
            state       <= S_IDLE;
            Bs          <= '0;
            Vs          <= '0;
            active_zone <= '0;
          end else if ((us_cur && cnt_inc >= CNT_W'(MIN_ON)) || cnt_inc == CNT_W'(MAX_ON)) begin
            state       <= S_GAP;
            cnt         <= '0;
            ptr         <= next_ptr;
            Bs          <= '0;
            Vs          <= '0;
            active_zone <= '0;
          end
        end
        S_GAP: begin
          cnt <= cnt_inc;
          if (cnt_inc == CNT_W'(GAP)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
